// File: rtl/hazard_control.sv
// Hazard/stall sequencer for the 5-stage RV32I core: load-use stalls, EX redirect flushes,
// data-memory wait freeze with timeout halt. Optional counters behind `HAZARD_STATS_EN.
module hazard_control #(
  parameter int MEM_TIMEOUT = 16,
  parameter int CNT_WIDTH   = 32
) (
  input  logic       clk,
  input  logic       rstn,
  input  logic [4:0] id_rs1,
  input  logic [4:0] id_rs2,
  input  logic       id_uses_rs1,
  input  logic       id_uses_rs2,
  input  logic       ex_mem_read,
  input  logic [4:0] ex_rd,
  input  logic       ex_redirect,
  input  logic       mem_req,
  input  logic       mem_ready,
  output logic       pc_write,
  output logic       ifid_write,
  output logic       ifid_flush,
  output logic       id_flush,
  output logic       ex_stall,
  output logic       wb_bubble,
  output logic       mem_error
`ifdef HAZARD_STATS_EN
  ,
  output logic [CNT_WIDTH-1:0] stall_cycles,
  output logic [CNT_WIDTH-1:0] flush_events
`endif
);

  if (MEM_TIMEOUT < 1 || CNT_WIDTH < 1) begin : g_bad_param
    $error("hazard_control: MEM_TIMEOUT and CNT_WIDTH must be >= 1");
  end

  localparam int WCW = $clog2(MEM_TIMEOUT + 1);
  localparam logic [WCW-1:0] W_ONE = WCW'(1);
  localparam logic [WCW-1:0] W_TMO = WCW'(MEM_TIMEOUT);

  typedef enum logic [1:0] {RUN, MEM_WAIT, HALT} state_t;

  typedef struct packed {
    logic pc_write;
    logic ifid_write;
    logic ifid_flush;
    logic id_flush;
    logic ex_stall;
    logic wb_bubble;
  } ctl_t;

  localparam ctl_t CTL_NORMAL = '{1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0};
  localparam ctl_t CTL_REDIR  = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0};
  localparam ctl_t CTL_LU     = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0};
  localparam ctl_t CTL_FREEZE = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1};
  localparam ctl_t CTL_HALT   = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1};
  localparam ctl_t CTL_RESET  = '{1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1};

  state_t         state, state_nxt;
  logic [WCW-1:0] wait_cnt, wait_cnt_nxt;
  logic           lu;
  ctl_t           ctl;

  assign lu = ex_mem_read && (ex_rd != 5'd0) &&
              ((id_uses_rs1 && (id_rs1 == ex_rd)) || (id_uses_rs2 && (id_rs2 == ex_rd)));

  // Redirect wins over load-use: the stalled ID instruction is squashed anyway.
  function automatic ctl_t run_ctl(input logic redir, input logic hz);
    if (redir)   return CTL_REDIR;
    else if (hz) return CTL_LU;
    else         return CTL_NORMAL;
  endfunction

  always_comb begin
    ctl          = CTL_NORMAL;
    state_nxt    = state;
    wait_cnt_nxt = wait_cnt;
    case (state)
      RUN: begin
        if (mem_req && !mem_ready) begin
          ctl          = CTL_FREEZE;
          state_nxt    = MEM_WAIT;
          wait_cnt_nxt = W_ONE;
        end else begin
          ctl = run_ctl(ex_redirect, lu);
        end
      end
      MEM_WAIT: begin
        if (!mem_ready) begin
          ctl = CTL_FREEZE;
          if (wait_cnt == W_TMO) state_nxt = HALT;
          else                   wait_cnt_nxt = wait_cnt + W_ONE;
        end else begin
          ctl          = run_ctl(ex_redirect, lu);
          state_nxt    = RUN;
          wait_cnt_nxt = '0;
        end
      end
      HALT:    ctl = CTL_HALT;
      default: state_nxt = RUN;
    endcase
    if (!rstn) ctl = CTL_RESET;
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state    <= RUN;
      wait_cnt <= '0;
    end else begin
      state    <= state_nxt;
      wait_cnt <= wait_cnt_nxt;
    end
  end

  assign {pc_write, ifid_write, ifid_flush, id_flush, ex_stall, wb_bubble} = ctl;
  assign mem_error = (state == HALT);

`ifdef HAZARD_STATS_EN
  localparam logic [CNT_WIDTH-1:0] C_ONE = CNT_WIDTH'(1);

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      stall_cycles <= '0;
      flush_events <= '0;
    end else begin
      if (!ctl.pc_write && state != HALT && stall_cycles != '1)
        stall_cycles <= stall_cycles + C_ONE;
      if (ctl.ifid_flush && flush_events != '1)
        flush_events <= flush_events + C_ONE;
    end
  end
`endif

endmodule

// File: tb/tb_hazard_control.sv
// Directed scoreboard bench for hazard_control: each driven step pushes its expected
// output vector, which is popped and compared on the following falling clock edge.
module tb_hazard_control;

  localparam int TMO = 4;
  localparam int CW  = 16;

  // {pc_write, ifid_write, ifid_flush, id_flush, ex_stall, wb_bubble, mem_error}
  localparam logic [6:0] E_NORM  = 7'b1100000;
  localparam logic [6:0] E_REDIR = 7'b1111000;
  localparam logic [6:0] E_LU    = 7'b0001000;
  localparam logic [6:0] E_FRZ   = 7'b0000110;
  localparam logic [6:0] E_HALT  = 7'b0001111;
  localparam logic [6:0] E_RST   = 7'b0011010;

  logic       clk = 1'b0;
  logic       rstn = 1'b0;
  logic [4:0] id_rs1 = '0, id_rs2 = '0, ex_rd = '0;
  logic       id_uses_rs1 = 1'b0, id_uses_rs2 = 1'b0, ex_mem_read = 1'b0;
  logic       ex_redirect = 1'b0, mem_req = 1'b0, mem_ready = 1'b0;
  logic       pc_write, ifid_write, ifid_flush, id_flush, ex_stall, wb_bubble, mem_error;
`ifdef HAZARD_STATS_EN
  logic [CW-1:0] stall_cycles, flush_events;
`endif

  hazard_control #(.MEM_TIMEOUT(TMO), .CNT_WIDTH(CW)) dut (
    .clk(clk), .rstn(rstn),
    .id_rs1(id_rs1), .id_rs2(id_rs2),
    .id_uses_rs1(id_uses_rs1), .id_uses_rs2(id_uses_rs2),
    .ex_mem_read(ex_mem_read), .ex_rd(ex_rd),
    .ex_redirect(ex_redirect), .mem_req(mem_req), .mem_ready(mem_ready),
    .pc_write(pc_write), .ifid_write(ifid_write), .ifid_flush(ifid_flush),
    .id_flush(id_flush), .ex_stall(ex_stall), .wb_bubble(wb_bubble),
    .mem_error(mem_error)
`ifdef HAZARD_STATS_EN
    , .stall_cycles(stall_cycles), .flush_events(flush_events)
`endif
  );

  always #5 clk = ~clk;

  logic [6:0] obs;
  assign obs = {pc_write, ifid_write, ifid_flush, id_flush, ex_stall, wb_bubble, mem_error};

  int total = 0;
  int bad   = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%h exp=%h @%0t", tag, got, exp, $time);
    end
  endtask

  typedef struct {
    string      tag;
    logic [6:0] exp;
  } sb_t;
  sb_t sb_q[$];

  always @(negedge clk) begin
    if (sb_q.size() > 0) begin
      sb_t e;
      e = sb_q.pop_front();
      chk(e.tag, 32'(obs), 32'(e.exp));
    end
  end

  // Drive one cycle of inputs, queue the expected outputs, advance to the next edge.
  task automatic st(input string tag, input logic [4:0] rs1, input logic u1,
                    input logic [4:0] rs2, input logic u2, input logic mrd,
                    input logic [4:0] rd, input logic redir, input logic mreq,
                    input logic mrdy, input logic [6:0] exp);
    sb_t e;
    id_rs1 = rs1; id_uses_rs1 = u1; id_rs2 = rs2; id_uses_rs2 = u2;
    ex_mem_read = mrd; ex_rd = rd; ex_redirect = redir;
    mem_req = mreq; mem_ready = mrdy;
    e.tag = tag; e.exp = exp;
    sb_q.push_back(e);
    @(posedge clk); #1;
  endtask

  task automatic reset_pulse(input string tag);
    sb_t e;
    rstn = 1'b0;
    #1;
    chk({tag, "_async"}, 32'(obs), 32'(E_RST));
    e.tag = tag; e.exp = E_RST;
    sb_q.push_back(e);
    @(posedge clk); #1;
    rstn = 1'b1;
  endtask

  // mem_ready held low from a fresh RUN state: freeze for TMO+1 cycles, then halt.
  task automatic timeout_seq(input string pfx);
    for (int i = 0; i <= TMO; i++)
      st({pfx, "_frz"}, 5'd5, 1'b1, 5'd0, 1'b0, 1'b1, 5'd5, (i % 2) == 1, 1'b1, 1'b0, E_FRZ);
    st({pfx, "_halt0"}, 5'd0, 1'b0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b1, 1'b0, E_HALT);
    st({pfx, "_halt1"}, 5'd0, 1'b0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b1, 1'b1, 1'b1, E_HALT);
    st({pfx, "_halt2"}, 5'd0, 1'b0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b0, E_HALT);
  endtask

  initial begin
    #1;
    chk("rst_async_init", 32'(obs), 32'(E_RST));
    @(posedge clk); #1;
    st("rst_held", 5'd0, 1'b0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b0, E_RST);
    rstn = 1'b1;

    //          tag            rs1  u1    rs2  u2    mrd   rd   redir mreq  mrdy  exp
    st("norm",        5'd1, 1'b1, 5'd2, 1'b1, 1'b0, 5'd0, 1'b0, 1'b0, 1'b0, E_NORM);
    st("lu",          5'd5, 1'b1, 5'd1, 1'b1, 1'b1, 5'd5, 1'b0, 1'b0, 1'b0, E_LU);
    st("lu_after",    5'd5, 1'b1, 5'd1, 1'b1, 1'b0, 5'd0, 1'b0, 1'b0, 1'b0, E_NORM);
    st("lu_rs2",      5'd0, 1'b0, 5'd7, 1'b1, 1'b1, 5'd7, 1'b0, 1'b0, 1'b0, E_LU);
    st("lu_nouse",    5'd3, 1'b1, 5'd7, 1'b0, 1'b1, 5'd7, 1'b0, 1'b0, 1'b0, E_NORM);
    st("x0_no_lu",    5'd0, 1'b1, 5'd0, 1'b1, 1'b1, 5'd0, 1'b0, 1'b0, 1'b0, E_NORM);
    st("redir_lu",    5'd5, 1'b1, 5'd1, 1'b0, 1'b1, 5'd5, 1'b1, 1'b0, 1'b0, E_REDIR);
    st("redir",       5'd1, 1'b1, 5'd2, 1'b1, 1'b0, 5'd9, 1'b1, 1'b0, 1'b0, E_REDIR);
    st("mem_fast",    5'd1, 1'b1, 5'd2, 1'b1, 1'b0, 5'd0, 1'b0, 1'b1, 1'b1, E_NORM);
    st("mem_fast_lu", 5'd8, 1'b1, 5'd2, 1'b1, 1'b1, 5'd8, 1'b0, 1'b1, 1'b1, E_LU);

    // Three-cycle memory wait; redirect/LU during the freeze must be ignored.
    reset_pulse("rst_pre_wait");
    st("mw_frz0",     5'd5, 1'b1, 5'd0, 1'b0, 1'b1, 5'd5, 1'b1, 1'b1, 1'b0, E_FRZ);
    st("mw_frz1",     5'd5, 1'b1, 5'd0, 1'b0, 1'b1, 5'd5, 1'b1, 1'b1, 1'b0, E_FRZ);
    st("mw_frz2",     5'd0, 1'b0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b1, 1'b0, E_FRZ);
    st("mw_rel_redir",5'd0, 1'b0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b1, 1'b1, 1'b1, E_REDIR);
    st("mw_run",      5'd0, 1'b0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b1, 1'b1, E_NORM);
`ifdef HAZARD_STATS_EN
    chk("stall_cycles", 32'(stall_cycles), 32'd3);
    chk("flush_events", 32'(flush_events), 32'd1);
`endif

    timeout_seq("to");
    reset_pulse("rst_halt");
    st("post_halt",   5'd1, 1'b1, 5'd2, 1'b1, 1'b0, 5'd0, 1'b0, 1'b0, 1'b0, E_NORM);

    // Async reset in the middle of a wait: must restart with a clean wait counter.
    st("mid_frz0",    5'd0, 1'b0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b1, 1'b0, E_FRZ);
    st("mid_frz1",    5'd0, 1'b0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b1, 1'b0, E_FRZ);
    #2;
    reset_pulse("rst_mid_wait");
    st("post_mid",    5'd1, 1'b1, 5'd2, 1'b1, 1'b0, 5'd0, 1'b0, 1'b0, 1'b0, E_NORM);
`ifdef HAZARD_STATS_EN
    chk("stall_clr",  32'(stall_cycles), 32'd0);
`endif
    timeout_seq("to2");

    @(negedge clk); #1;
    chk("sb_drained", 32'(sb_q.size()), 32'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #50000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog expired");
  end

endmodule
